// File: rtl/piton_chan_rx_buffer.sv
// piton_chan_rx_buffer
// Receive-side buffer for one OpenPiton-style NoC channel.
//
// Every valid flit from the link is written into a DEPTH-entry FIFO. The FIFO
// head is presented to local logic on a ready/valid interface. One yummy
// credit pulse goes back upstream for every flit popped.
//
// The upstream sender starts with DEPTH credits, so in normal operation the
// buffer never overruns. If a flit does arrive with no room, it is dropped and
// a sticky overflow flag is raised for debug.
//
// Occupancy states are implied by the counter alone: EMPTY (0), PARTIAL, and
// FULL (DEPTH). There is no separate state machine.
module piton_chan_rx_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      chan_data_i,
  input  logic                       chan_valid_i,
  output logic                       chan_yummy_o,
  output logic [DATA_WIDTH-1:0]      dout_o,
  output logic                       dout_valid_o,
  input  logic                       dout_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and pointers
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  yummy_q;
  logic                  overflow_q, overflow_d;

  // Per-cycle handshake decisions
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Pointer advance with an explicit wrap. DEPTH need not be a power of two,
  // so natural binary rollover cannot be relied on.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // A pop while full frees a slot in the same cycle. That lets a simultaneous
  // push land, which keeps one-in/one-out throughput even at FULL.
  assign pop  = ~empty & dout_ready_i;
  assign push = chan_valid_i & (~full | pop);
  assign drop = chan_valid_i & ~push;

  // Next-state for pointers, occupancy and the sticky error flag
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | drop;
    if (push) begin
      wp_d = ptr_inc(wp_q);
    end
    if (pop) begin
      rp_d = ptr_inc(rp_q);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state register; reset discards all held flits and any pending credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      yummy_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      yummy_q    <= pop;
      overflow_q <= overflow_d;
    end
  end

  // Flit storage; contents are meaningless until written, so it is not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= chan_data_i;
    end
  end

  // Head is read straight from storage. There is no empty bypass, so a flit
  // first becomes visible in the cycle after it arrives.
  assign dout_o       = mem_q[rp_q];
  assign dout_valid_o = ~empty;
  assign count_o      = cnt_q;
  assign chan_yummy_o = yummy_q;
  assign overflow_o   = overflow_q;

endmodule
